// File: rtl/mc_rdata_pack.sv
// Packs consecutive array read beats into R-channel words, one burst descriptor at a time,
// and buffers the packed words in a small FIFO that drives the AXI read data channel.
module mc_rdata_pack #(
    parameter int ARRAY_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH   = 256,
    parameter int CMD_DEPTH        = 2,
    parameter int DATA_DEPTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [7:0]                  cmd_len,
    input  logic                        array_rdata_vld,
    input  logic [ARRAY_DATA_WIDTH-1:0] array_rdata,
    output logic                        axi_s_rvalid,
    input  logic                        axi_s_rready,
    output logic                        axi_s_rlast,
    output logic [AXI_DATA_WIDTH-1:0]   axi_s_rdata,
    output logic                        rd_space,
    output logic                        pack_busy,
    output logic                        pack_err
);

    localparam int LANES = AXI_DATA_WIDTH / ARRAY_DATA_WIDTH;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CAW   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int DAW   = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PACK = 1'b1} state_e;

    state_e                    state_q, state_d;
    logic [LW-1:0]             lane_q, lane_d;
    logic [7:0]                wcnt_q, wcnt_d;
    logic [AXI_DATA_WIDTH-1:0] pack_q, pack_d;
    logic                      err_q, err_d;

    logic [7:0]                cmd_mem_q [CMD_DEPTH];
    logic [7:0]                cmd_mem_d [CMD_DEPTH];
    logic [CAW-1:0]            cmd_wr_idx_q, cmd_wr_idx_d, cmd_rd_idx_q, cmd_rd_idx_d;
    logic                      cmd_wr_wrap_q, cmd_wr_wrap_d, cmd_rd_wrap_q, cmd_rd_wrap_d;

    logic [AXI_DATA_WIDTH:0]   dat_mem_q [DATA_DEPTH];
    logic [AXI_DATA_WIDTH:0]   dat_mem_d [DATA_DEPTH];
    logic [DAW-1:0]            dat_wr_idx_q, dat_wr_idx_d, dat_rd_idx_q, dat_rd_idx_d;
    logic                      dat_wr_wrap_q, dat_wr_wrap_d, dat_rd_wrap_q, dat_rd_wrap_d;

    logic                      cmd_empty_s, cmd_full_s, cmd_push_s, cmd_pop_s, cmd_last_one_s;
    logic                      dat_empty_s, dat_full_s, dat_push_s, dat_pop_s;
    logic                      beat_acc_s, word_done_s, word_last_s;
    logic [CAW-1:0]            cmd_wr_idx_inc_s, cmd_rd_idx_inc_s;
    logic                      cmd_wr_wrap_inc_s, cmd_rd_wrap_inc_s;
    logic [DAW-1:0]            dat_wr_idx_inc_s, dat_rd_idx_inc_s;
    logic                      dat_wr_wrap_inc_s, dat_rd_wrap_inc_s;
    logic [AXI_DATA_WIDTH-1:0] word_s;
    logic [7:0]                head_len_s;
    int                        dcnt_s, free_s;

    // FIFO status and pointer successors; the wrap bit toggles each pass so full and empty stay distinct.
    always_comb begin
        cmd_empty_s       = (cmd_wr_idx_q == cmd_rd_idx_q) && (cmd_wr_wrap_q == cmd_rd_wrap_q);
        cmd_full_s        = (cmd_wr_idx_q == cmd_rd_idx_q) && (cmd_wr_wrap_q != cmd_rd_wrap_q);
        dat_empty_s       = (dat_wr_idx_q == dat_rd_idx_q) && (dat_wr_wrap_q == dat_rd_wrap_q);
        dat_full_s        = (dat_wr_idx_q == dat_rd_idx_q) && (dat_wr_wrap_q != dat_rd_wrap_q);
        cmd_wr_idx_inc_s  = (cmd_wr_idx_q == CAW'(CMD_DEPTH-1)) ? CAW'(0) : cmd_wr_idx_q + CAW'(1);
        cmd_wr_wrap_inc_s = cmd_wr_wrap_q ^ (cmd_wr_idx_q == CAW'(CMD_DEPTH-1));
        cmd_rd_idx_inc_s  = (cmd_rd_idx_q == CAW'(CMD_DEPTH-1)) ? CAW'(0) : cmd_rd_idx_q + CAW'(1);
        cmd_rd_wrap_inc_s = cmd_rd_wrap_q ^ (cmd_rd_idx_q == CAW'(CMD_DEPTH-1));
        dat_wr_idx_inc_s  = (dat_wr_idx_q == DAW'(DATA_DEPTH-1)) ? DAW'(0) : dat_wr_idx_q + DAW'(1);
        dat_wr_wrap_inc_s = dat_wr_wrap_q ^ (dat_wr_idx_q == DAW'(DATA_DEPTH-1));
        dat_rd_idx_inc_s  = (dat_rd_idx_q == DAW'(DATA_DEPTH-1)) ? DAW'(0) : dat_rd_idx_q + DAW'(1);
        dat_rd_wrap_inc_s = dat_rd_wrap_q ^ (dat_rd_idx_q == DAW'(DATA_DEPTH-1));
        cmd_last_one_s    = (cmd_rd_idx_inc_s == cmd_wr_idx_q) && (cmd_rd_wrap_inc_s == cmd_wr_wrap_q);
        dcnt_s            = (dat_wr_wrap_q == dat_rd_wrap_q)
                          ? (int'(dat_wr_idx_q) - int'(dat_rd_idx_q))
                          : (DATA_DEPTH - int'(dat_rd_idx_q) + int'(dat_wr_idx_q));
        free_s            = DATA_DEPTH - dcnt_s - int'(lane_q != LW'(0));
    end

    // Beat packing, burst bookkeeping, FIFO updates and the packer state.
    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        wcnt_d        = wcnt_q;
        pack_d        = pack_q;
        err_d         = err_q;
        cmd_mem_d     = cmd_mem_q;
        dat_mem_d     = dat_mem_q;
        cmd_wr_idx_d  = cmd_wr_idx_q;
        cmd_wr_wrap_d = cmd_wr_wrap_q;
        cmd_rd_idx_d  = cmd_rd_idx_q;
        cmd_rd_wrap_d = cmd_rd_wrap_q;
        dat_wr_idx_d  = dat_wr_idx_q;
        dat_wr_wrap_d = dat_wr_wrap_q;
        dat_rd_idx_d  = dat_rd_idx_q;
        dat_rd_wrap_d = dat_rd_wrap_q;

        head_len_s  = cmd_mem_q[cmd_rd_idx_q];
        cmd_push_s  = cmd_valid && !cmd_full_s && !rst;
        beat_acc_s  = array_rdata_vld && !cmd_empty_s;
        word_done_s = beat_acc_s && (lane_q == LW'(LANES-1));
        word_last_s = word_done_s && (wcnt_q == head_len_s);
        cmd_pop_s   = word_last_s;
        dat_pop_s   = !dat_empty_s && axi_s_rready;
        dat_push_s  = word_done_s && (!dat_full_s || dat_pop_s);

        word_s = pack_q;
        word_s[int'(lane_q)*ARRAY_DATA_WIDTH +: ARRAY_DATA_WIDTH] = array_rdata;

        if (beat_acc_s) begin
            lane_d = word_done_s ? LW'(0) : lane_q + LW'(1);
            pack_d = word_s;
        end else begin
            lane_d = lane_q;
        end

        if (word_done_s) begin
            wcnt_d = word_last_s ? 8'd0 : wcnt_q + 8'd1;
        end else begin
            wcnt_d = wcnt_q;
        end

        // Stray beats and words with nowhere to go are lost; the flag stays up until reset.
        if ((array_rdata_vld && cmd_empty_s) || (word_done_s && dat_full_s && !dat_pop_s)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (cmd_push_s) begin
            cmd_mem_d[cmd_wr_idx_q] = cmd_len;
            cmd_wr_idx_d            = cmd_wr_idx_inc_s;
            cmd_wr_wrap_d           = cmd_wr_wrap_inc_s;
        end else begin
            cmd_wr_idx_d = cmd_wr_idx_q;
        end

        if (cmd_pop_s) begin
            cmd_rd_idx_d  = cmd_rd_idx_inc_s;
            cmd_rd_wrap_d = cmd_rd_wrap_inc_s;
        end else begin
            cmd_rd_idx_d = cmd_rd_idx_q;
        end

        if (dat_push_s) begin
            dat_mem_d[dat_wr_idx_q] = {word_last_s, word_s};
            dat_wr_idx_d            = dat_wr_idx_inc_s;
            dat_wr_wrap_d           = dat_wr_wrap_inc_s;
        end else begin
            dat_wr_idx_d = dat_wr_idx_q;
        end

        if (dat_pop_s) begin
            dat_rd_idx_d  = dat_rd_idx_inc_s;
            dat_rd_wrap_d = dat_rd_wrap_inc_s;
        end else begin
            dat_rd_idx_d = dat_rd_idx_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_push_s) begin
                    state_d = ST_PACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PACK: begin
                if (cmd_pop_s && cmd_last_one_s && !cmd_push_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PACK;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; a reset drops every partial and queued item.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lane_q        <= '0;
            wcnt_q        <= 8'd0;
            pack_q        <= '0;
            err_q         <= 1'b0;
            cmd_wr_idx_q  <= '0;
            cmd_wr_wrap_q <= 1'b0;
            cmd_rd_idx_q  <= '0;
            cmd_rd_wrap_q <= 1'b0;
            dat_wr_idx_q  <= '0;
            dat_wr_wrap_q <= 1'b0;
            dat_rd_idx_q  <= '0;
            dat_rd_wrap_q <= 1'b0;
            for (int i = 0; i < CMD_DEPTH; i++) cmd_mem_q[i] <= 8'd0;
            for (int i = 0; i < DATA_DEPTH; i++) dat_mem_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            wcnt_q        <= wcnt_d;
            pack_q        <= pack_d;
            err_q         <= err_d;
            cmd_wr_idx_q  <= cmd_wr_idx_d;
            cmd_wr_wrap_q <= cmd_wr_wrap_d;
            cmd_rd_idx_q  <= cmd_rd_idx_d;
            cmd_rd_wrap_q <= cmd_rd_wrap_d;
            dat_wr_idx_q  <= dat_wr_idx_d;
            dat_wr_wrap_q <= dat_wr_wrap_d;
            dat_rd_idx_q  <= dat_rd_idx_d;
            dat_rd_wrap_q <= dat_rd_wrap_d;
            cmd_mem_q     <= cmd_mem_d;
            dat_mem_q     <= dat_mem_d;
        end
    end

    // Outputs come straight from registered state; the head is forced to zero while the FIFO is empty.
    always_comb begin
        cmd_ready    = !cmd_full_s && !rst;
        axi_s_rvalid = !dat_empty_s;
        axi_s_rdata  = dat_empty_s ? '0 : dat_mem_q[dat_rd_idx_q][AXI_DATA_WIDTH-1:0];
        axi_s_rlast  = dat_empty_s ? 1'b0 : dat_mem_q[dat_rd_idx_q][AXI_DATA_WIDTH];
        rd_space     = (free_s >= 1);
        pack_busy    = (state_q == ST_PACK) || (lane_q != LW'(0)) || !dat_empty_s;
        pack_err     = err_q;
    end

endmodule

// File: tb/tb_mc_rdata_pack.sv
// Directed bench for mc_rdata_pack: hand-built beat patterns, expected words assembled locally.
module tb_mc_rdata_pack;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [7:0]   cmd_len;
    logic         array_rdata_vld;
    logic [63:0]  array_rdata;
    logic         axi_s_rvalid;
    logic         axi_s_rready;
    logic         axi_s_rlast;
    logic [255:0] axi_s_rdata;
    logic         rd_space;
    logic         pack_busy;
    logic         pack_err;

    int nvec = 0;
    int nerr = 0;
    logic [255:0] got_data[$];
    logic         got_last[$];

    mc_rdata_pack dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .array_rdata_vld(array_rdata_vld), .array_rdata(array_rdata),
        .axi_s_rvalid(axi_s_rvalid), .axi_s_rready(axi_s_rready),
        .axi_s_rlast(axi_s_rlast), .axi_s_rdata(axi_s_rdata),
        .rd_space(rd_space), .pack_busy(pack_busy), .pack_err(pack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mkbeat(input int i);
        return {32'h0BEA_D000, 32'(i)};
    endfunction

    function automatic logic [255:0] mkword(input int first);
        return {mkbeat(first + 3), mkbeat(first + 2), mkbeat(first + 1), mkbeat(first)};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle; a word popped at this edge is recorded before the edge.
    task automatic step(input logic vld, input logic [63:0] d);
        array_rdata_vld = vld;
        array_rdata     = d;
        if (axi_s_rvalid && axi_s_rready) begin
            got_data.push_back(axi_s_rdata);
            got_last.push_back(axi_s_rlast);
        end
        @(posedge clk);
        #1;
        array_rdata_vld = 1'b0;
        cmd_valid       = 1'b0;
    endtask

    task automatic drain(input int n);
        axi_s_rready = 1'b1;
        for (int i = 0; i < n; i++) step(1'b0, 64'd0);
    endtask

    task automatic send_cmd(input logic [7:0] len);
        cmd_valid = 1'b1;
        cmd_len   = len;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        step(1'b0, 64'd0);
        rst = 1'b0;
        step(1'b0, 64'd0);
        got_data.delete();
        got_last.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nl;
        rst = 1'b1; cmd_valid = 1'b0; cmd_len = 8'd0;
        array_rdata_vld = 1'b0; array_rdata = 64'd0; axi_s_rready = 1'b1;
        step(1'b0, 64'd0);
        step(1'b0, 64'd0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rvalid", axi_s_rvalid, 1'b0);
        rst = 1'b0;
        step(1'b0, 64'd0);
        chk("por_cmd_ready", cmd_ready, 1'b1);
        chk("por_rlast", axi_s_rlast, 1'b0);
        chk("por_rdata", axi_s_rdata, 256'd0);
        chk("por_rd_space", rd_space, 1'b1);
        chk("por_busy", pack_busy, 1'b0);
        chk("por_err", pack_err, 1'b0);

        // single-word burst, latency of one cycle after the fourth beat
        send_cmd(8'd0);
        step(1'b0, 64'd0);
        step(1'b1, 64'h1111_1111_1111_1111);
        step(1'b1, 64'h2222_2222_2222_2222);
        step(1'b1, 64'h3333_3333_3333_3333);
        chk("t1_early_rvalid", axi_s_rvalid, 1'b0);
        step(1'b1, 64'h4444_4444_4444_4444);
        chk("t1_rvalid", axi_s_rvalid, 1'b1);
        chk("t1_rdata", axi_s_rdata,
            256'h4444_4444_4444_4444_3333_3333_3333_3333_2222_2222_2222_2222_1111_1111_1111_1111);
        chk("t1_rlast", axi_s_rlast, 1'b1);
        chk("t1_busy", pack_busy, 1'b1);
        step(1'b0, 64'd0);
        chk("t1_rvalid_after", axi_s_rvalid, 1'b0);
        chk("t1_busy_after", pack_busy, 1'b0);
        got_data.delete(); got_last.delete();

        // four-word burst with continuous readiness
        send_cmd(8'd3);
        step(1'b0, 64'd0);
        for (int i = 0; i < 16; i++) step(1'b1, mkbeat(i));
        chk("t2_busy_mid", pack_busy, 1'b1);
        drain(4);
        chk("t2_count", 256'(got_data.size()), 256'd4);
        for (int j = 0; j < 4 && j < got_data.size(); j++) begin
            chk($sformatf("t2_data%0d", j), got_data[j], mkword(4 * j));
            chk($sformatf("t2_last%0d", j), got_last[j], (j == 3) ? 1'b1 : 1'b0);
        end
        chk("t2_busy_end", pack_busy, 1'b0);
        got_data.delete(); got_last.delete();

        // stalled reader: space indication and overflow drop
        axi_s_rready = 1'b0;
        send_cmd(8'd4);
        step(1'b0, 64'd0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, mkbeat(i));
            if (i == 11) chk("t3_space_3w", rd_space, 1'b1);
            if (i == 12) chk("t3_space_partial", rd_space, 1'b0);
            if (i == 15) begin
                chk("t3_space_full", rd_space, 1'b0);
                chk("t3_err_before", pack_err, 1'b0);
            end
        end
        chk("t3_err", pack_err, 1'b1);
        drain(8);
        chk("t3_count", 256'(got_data.size()), 256'd4);
        if (got_data.size() == 4) begin
            chk("t3_data0", got_data[0], mkword(0));
            chk("t3_last3", got_last[3], 1'b0);
        end
        do_reset();
        chk("t3_err_cleared", pack_err, 1'b0);

        // push and pop together while the data FIFO is full
        axi_s_rready = 1'b0;
        send_cmd(8'd4);
        step(1'b0, 64'd0);
        for (int i = 0; i < 20; i++) begin
            if (i == 19) axi_s_rready = 1'b1;
            step(1'b1, mkbeat(i));
        end
        chk("t4_err", pack_err, 1'b0);
        drain(8);
        chk("t4_count", 256'(got_data.size()), 256'd5);
        if (got_data.size() == 5) begin
            chk("t4_data4", got_data[4], mkword(16));
            chk("t4_last4", got_last[4], 1'b1);
        end
        got_data.delete(); got_last.delete();

        // beat with no descriptor, then a normal burst
        step(1'b1, 64'hDEAD_BEEF_0000_0001);
        chk("t5_rvalid", axi_s_rvalid, 1'b0);
        chk("t5_err", pack_err, 1'b1);
        chk("t5_busy", pack_busy, 1'b0);
        send_cmd(8'd0);
        step(1'b0, 64'd0);
        for (int i = 100; i < 104; i++) step(1'b1, mkbeat(i));
        drain(3);
        chk("t5_count", 256'(got_data.size()), 256'd1);
        if (got_data.size() == 1) begin
            chk("t5_data", got_data[0], mkword(100));
            chk("t5_last", got_last[0], 1'b1);
        end
        do_reset();

        // back-to-back descriptors with continuous beats
        send_cmd(8'd1);
        step(1'b0, 64'd0);
        send_cmd(8'd0);
        step(1'b1, mkbeat(0));
        chk("t6_cmd_full", cmd_ready, 1'b0);
        for (int i = 1; i < 12; i++) step(1'b1, mkbeat(i));
        drain(4);
        chk("t6_count", 256'(got_data.size()), 256'd3);
        if (got_data.size() == 3) begin
            chk("t6_last0", got_last[0], 1'b0);
            chk("t6_last1", got_last[1], 1'b1);
            chk("t6_last2", got_last[2], 1'b1);
            chk("t6_data2", got_data[2], mkword(8));
        end
        got_data.delete(); got_last.delete();

        // reset in the middle of a burst
        send_cmd(8'd0);
        step(1'b0, 64'd0);
        step(1'b1, mkbeat(50));
        step(1'b1, mkbeat(51));
        rst = 1'b1;
        step(1'b0, 64'd0);
        chk("t7_rst_rvalid", axi_s_rvalid, 1'b0);
        chk("t7_rst_busy", pack_busy, 1'b0);
        chk("t7_rst_cmd_ready", cmd_ready, 1'b0);
        chk("t7_rst_space", rd_space, 1'b1);
        rst = 1'b0;
        step(1'b0, 64'd0);
        chk("t7_post_rvalid", axi_s_rvalid, 1'b0);
        chk("t7_post_cmd_ready", cmd_ready, 1'b1);
        got_data.delete(); got_last.delete();
        send_cmd(8'd0);
        step(1'b0, 64'd0);
        for (int i = 60; i < 64; i++) step(1'b1, mkbeat(i));
        drain(3);
        chk("t7_count", 256'(got_data.size()), 256'd1);
        if (got_data.size() == 1) chk("t7_data", got_data[0], mkword(60));
        got_data.delete(); got_last.delete();

        // longest burst: 256 words, only the final one tagged
        send_cmd(8'd255);
        step(1'b0, 64'd0);
        for (int i = 0; i < 1024; i++) step(1'b1, mkbeat(i));
        drain(4);
        chk("t8_count", 256'(got_data.size()), 256'd256);
        nl = 0;
        foreach (got_last[k]) nl += int'(got_last[k]);
        chk("t8_nlast", 256'(nl), 256'd1);
        if (got_data.size() == 256) begin
            chk("t8_last255", got_last[255], 1'b1);
            chk("t8_data255", got_data[255], mkword(1020));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
